// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port-write / combinational-read data RAM.
// Full-word writes and reads take one cycle to respond; partial writes do a read-merge-write cycle first.
module mem_arbiter #(
    parameter int unsigned DEPTH = 9,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_i,
    input  logic [1:0]    we_i,
    input  logic [31:0]   addr0_i,
    input  logic [31:0]   addr1_i,
    input  logic [31:0]   wdata0_i,
    input  logic [31:0]   wdata1_i,
    input  logic [3:0]    be0_i,
    input  logic [3:0]    be1_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    rsp_valid_o,
    output logic          rsp_err_o,
    output logic [31:0]   rsp_rdata_o,
    output logic [AW-1:0] ram_raddr_o,
    input  logic [31:0]   ram_rdata_i,
    output logic [AW-1:0] ram_waddr_o,
    output logic [31:0]   ram_wdata_o,
    output logic          ram_we_o
);

    localparam int unsigned WW = 30;
    localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH);

    typedef enum logic [1:0] {IDLE, MERGE, RESP} state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   word_q, word_d;

    logic          sel;
    logic          accept;
    logic [WW-1:0] sel_word;
    logic [AW-1:0] sel_idx;
    logic          sel_oor;
    logic          sel_we;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;
    logic [31:0]   merged;

    // Byte offset bits carry no meaning for word accesses.
    logic unused_addr;
    assign unused_addr = ^{addr0_i[1:0], addr1_i[1:0]};

    // Port selection: contention resolved by prio, a lone requester always wins.
    always_comb begin
        sel       = (req_i == 2'b11) ? prio_q : req_i[1];
        sel_word  = sel ? addr1_i[31:2] : addr0_i[31:2];
        sel_idx   = sel_word[AW-1:0];
        sel_oor   = (sel_word >= DEPTH_W);
        sel_we    = sel ? we_i[1] : we_i[0];
        sel_wdata = sel ? wdata1_i : wdata0_i;
        sel_be    = sel ? be1_i : be0_i;
        accept    = (|req_i) && !rst_n;
        for (int n = 0; n < 4; n++) begin
            merged[8*n +: 8] = be_q[n] ? wdata_q[8*n +: 8] : word_q[8*n +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        we_d        = we_q;
        err_d       = err_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        word_d      = word_q;
        gnt_o       = 2'b00;
        rsp_valid_o = 2'b00;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = 32'h0;
        ram_raddr_o = idx_q;
        ram_waddr_o = idx_q;
        ram_wdata_o = 32'h0;
        ram_we_o    = 1'b0;
        case (state_q)
            IDLE: begin
                ram_raddr_o = sel_idx;
                if (accept) begin
                    gnt_o   = sel ? 2'b10 : 2'b01;
                    prio_d  = ~sel;
                    owner_d = sel;
                    we_d    = sel_we;
                    err_d   = sel_oor;
                    idx_d   = sel_idx;
                    wdata_d = sel_wdata;
                    be_d    = sel_be;
                    word_d  = sel_oor ? 32'h0 : ram_rdata_i;
                    state_d = RESP;
                    if (!sel_oor && sel_we) begin
                        if (sel_be == 4'b1111) begin
                            ram_we_o    = 1'b1;
                            ram_waddr_o = sel_idx;
                            ram_wdata_o = sel_wdata;
                        end else if (sel_be != 4'b0000) begin
                            state_d = MERGE;
                        end
                    end
                end
            end
            MERGE: begin
                ram_we_o    = 1'b1;
                ram_wdata_o = merged;
                state_d     = RESP;
            end
            RESP: begin
                rsp_valid_o = owner_q ? 2'b10 : 2'b01;
                rsp_err_o   = err_q;
                rsp_rdata_o = (!we_q && !err_q) ? word_q : 32'h0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            word_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM attached to its RAM ports.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [31:0] addr0_i, addr1_i;
    logic [31:0] wdata0_i, wdata1_i;
    logic [3:0]  be0_i, be1_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rsp_valid_o;
    logic        rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [3:0]  ram_raddr_o;
    logic [31:0] ram_rdata_i;
    logic [3:0]  ram_waddr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_we_o;

    logic [31:0] mem [16];
    logic        mem_init;

    int checks;
    int errors;

    mem_arbiter #(.DEPTH(9), .AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr0_i    (addr0_i),
        .addr1_i    (addr1_i),
        .wdata0_i   (wdata0_i),
        .wdata1_i   (wdata1_i),
        .be0_i      (be0_i),
        .be1_i      (be1_i),
        .gnt_o      (gnt_o),
        .rsp_valid_o(rsp_valid_o),
        .rsp_err_o  (rsp_err_o),
        .rsp_rdata_o(rsp_rdata_o),
        .ram_raddr_o(ram_raddr_o),
        .ram_rdata_i(ram_rdata_i),
        .ram_waddr_o(ram_waddr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_we_o   (ram_we_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: word i preset to 0x1000_000i, combinational read.
    assign ram_rdata_i = mem[ram_raddr_o];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (ram_we_o) begin
            mem[ram_waddr_o] <= ram_wdata_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        mem_init = 1'b1;
        req_i    = 2'b11;
        we_i     = 2'b00;
        addr0_i  = 32'h0;
        addr1_i  = 32'h0;
        wdata0_i = 32'h0;
        wdata1_i = 32'h0;
        be0_i    = 4'h0;
        be1_i    = 4'h0;

        // Reset held with both ports requesting: everything quiet
        mid();
        chk("rst_gnt",   32'(gnt_o), 32'h0);
        chk("rst_rsp",   32'(rsp_valid_o), 32'h0);
        chk("rst_err",   32'(rsp_err_o), 32'h0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_we",    32'(ram_we_o), 32'h0);
        tick();
        rst_n    = 1'b0;
        mem_init = 1'b0;
        req_i    = 2'b00;

        // Port0 full write to word 2, port1 raises a read while arbiter is in RESP
        req_i = 2'b01; we_i = 2'b01; addr0_i = 32'h8; wdata0_i = 32'hDEADBEEF; be0_i = 4'hF;
        mid();
        chk("fw_gnt",   32'(gnt_o), 32'h1);
        chk("fw_we",    32'(ram_we_o), 32'h1);
        chk("fw_waddr", 32'(ram_waddr_o), 32'h2);
        chk("fw_wdata", ram_wdata_o, 32'hDEADBEEF);
        tick();
        req_i = 2'b10; we_i = 2'b00; addr1_i = 32'h8;
        mid();
        chk("fw_rsp",       32'(rsp_valid_o), 32'h1);
        chk("fw_rsp_err",   32'(rsp_err_o), 32'h0);
        chk("fw_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("resp_no_gnt",  32'(gnt_o), 32'h0);
        chk("fw_mem2",      mem[2], 32'hDEADBEEF);
        tick();
        mid();
        chk("rd_gnt",   32'(gnt_o), 32'h2);
        chk("rd_raddr", 32'(ram_raddr_o), 32'h2);
        tick();
        req_i = 2'b00;
        mid();
        chk("rd_rsp",   32'(rsp_valid_o), 32'h2);
        chk("rd_rdata", rsp_rdata_o, 32'hDEADBEEF);
        chk("rd_err",   32'(rsp_err_o), 32'h0);

        // Partial write to lane 2 of word 2: RAM written only in MERGE
        tick();
        req_i = 2'b01; we_i = 2'b01; addr0_i = 32'h8; wdata0_i = 32'h00AA0000; be0_i = 4'b0100;
        mid();
        chk("pw_gnt",     32'(gnt_o), 32'h1);
        chk("pw_acc_we",  32'(ram_we_o), 32'h0);
        tick();
        req_i = 2'b00;
        mid();
        chk("pw_mrg_we",    32'(ram_we_o), 32'h1);
        chk("pw_mrg_waddr", 32'(ram_waddr_o), 32'h2);
        chk("pw_mrg_wdata", ram_wdata_o, 32'hDEAABEEF);
        chk("pw_mrg_rsp",   32'(rsp_valid_o), 32'h0);
        tick();
        mid();
        chk("pw_rsp",   32'(rsp_valid_o), 32'h1);
        chk("pw_rdata", rsp_rdata_o, 32'h0);
        chk("pw_resp_we", 32'(ram_we_o), 32'h0);
        chk("pw_mem2",  mem[2], 32'hDEAABEEF);

        // Write with no byte enables: response but RAM untouched
        tick();
        req_i = 2'b01; we_i = 2'b01; addr0_i = 32'h10; wdata0_i = 32'hFFFFFFFF; be0_i = 4'b0000;
        mid();
        chk("be0_gnt", 32'(gnt_o), 32'h1);
        chk("be0_we",  32'(ram_we_o), 32'h0);
        tick();
        req_i = 2'b00;
        mid();
        chk("be0_rsp",  32'(rsp_valid_o), 32'h1);
        chk("be0_err",  32'(rsp_err_o), 32'h0);
        chk("be0_mem4", mem[4], 32'h10000004);

        // Port1 read of word 9, one past the end
        tick();
        req_i = 2'b10; we_i = 2'b00; addr1_i = 32'h24;
        mid();
        chk("oor_gnt", 32'(gnt_o), 32'h2);
        chk("oor_acc_we", 32'(ram_we_o), 32'h0);
        tick();
        req_i = 2'b00;
        mid();
        chk("oor_rsp",   32'(rsp_valid_o), 32'h2);
        chk("oor_err",   32'(rsp_err_o), 32'h1);
        chk("oor_rdata", rsp_rdata_o, 32'h0);
        chk("oor_we",    32'(ram_we_o), 32'h0);

        // Reset hits MERGE of a partial write to word 3
        tick();
        req_i = 2'b01; we_i = 2'b01; addr0_i = 32'hC; wdata0_i = 32'h00005555; be0_i = 4'b0011;
        mid();
        chk("mrst_gnt", 32'(gnt_o), 32'h1);
        tick();
        req_i = 2'b00;
        #1;
        rst_n = 1'b1;
        mid();
        chk("mrst_we",  32'(ram_we_o), 32'h0);
        chk("mrst_rsp", 32'(rsp_valid_o), 32'h0);
        chk("mrst_gnt0", 32'(gnt_o), 32'h0);
        tick();
        rst_n = 1'b0;
        mid();
        chk("mrst_rsp_after", 32'(rsp_valid_o), 32'h0);
        chk("mrst_we_after",  32'(ram_we_o), 32'h0);
        chk("mrst_mem3",      mem[3], 32'h10000003);

        // Both ports read continuously: grants alternate starting at port0
        tick();
        req_i = 2'b11; we_i = 2'b00; addr0_i = 32'h4; addr1_i = 32'h14;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("alt_gnt", 32'(gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            mid();
            chk("alt_rsp",   32'(rsp_valid_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("alt_rdata", rsp_rdata_o, (i % 2 == 0) ? 32'h10000001 : 32'h10000005);
            tick();
        end
        req_i = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 9: number of 32-bit words in the attached data RAM.
REQ-002 Parameter AW, default 4: RAM word-address width; DEPTH <= 2**AW.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-high (asserted = 1).
REQ-005 req_i  input  2  per-port request; bit k = port k (0 = core LSU, 1 = loader/debug).
REQ-006 we_i  input  2  per-port write (1) / read (0).
REQ-007 addr0_i, addr1_i  input  32 each  byte addresses; word index = addr[AW+1:2], addr[1:0] ignored.
REQ-008 wdata0_i, wdata1_i  input  32 each  write data, lane-aligned.
REQ-009 be0_i, be1_i  input  4 each  byte enables; bit n covers wdata[8n+7:8n].
REQ-010 gnt_o  output  2  one-hot grant pulse, one cycle, marks acceptance.
REQ-011 rsp_valid_o  output  2  one-hot response pulse, one cycle.
REQ-012 rsp_err_o  output  1  error flag, valid with rsp_valid_o.
REQ-013 rsp_rdata_o  output  32  read data, valid with rsp_valid_o.
REQ-014 ram_raddr_o  output  AW  RAM read address; RAM read is combinational.
REQ-015 ram_rdata_i  input  32  RAM read data.
REQ-016 ram_waddr_o, ram_wdata_o, ram_we_o  output  AW, 32, 1  RAM write port, written at rising clk when ram_we_o = 1.

Function
REQ-017 FSM states IDLE, MERGE, RESP; only IDLE accepts requests.
REQ-018 IDLE with any req_i bit set: grant combinationally that cycle; one port only.
REQ-019 Arbitration round-robin: pointer prio; both requesting -> port prio wins; single requester always wins.
REQ-020 After grant to port k, prio <= 1-k; prio unchanged when no grant.
REQ-021 Accept cycle: latch port id, we, word index, wdata, be; drive ram_raddr_o = word index.
REQ-022 Out of range (addr[31:2] >= DEPTH): no RAM write; rsp_err_o = 1, rsp_rdata_o = 0; IDLE -> RESP.
REQ-023 Read: capture ram_rdata_i at accept edge; IDLE -> RESP; gnt-to-rsp latency 1 cycle.
REQ-024 Write with be = 4'b1111: ram_we_o = 1 in accept cycle with ram_wdata_o = wdata; IDLE -> RESP; latency 1.
REQ-025 Write with be = 4'b0000: no RAM write, no error; IDLE -> RESP.
REQ-026 Partial write (other be): capture old word at accept; IDLE -> MERGE.
REQ-027 MERGE: ram_we_o = 1, ram_wdata_o = enabled lanes from wdata, others from captured word; MERGE -> RESP; latency 2.
REQ-028 RESP: rsp_valid_o[owner] = 1 for one cycle; rsp_rdata_o = captured word (reads), 0 (writes); RESP -> IDLE.
REQ-029 Max throughput: one read/full write per 2 cycles, one partial write per 3 cycles.
REQ-030 Requester holds req/we/addr/wdata/be until gnt; may drop req after gnt; req outside IDLE ignored (no gnt).
REQ-031 ram_we_o asserted in at most one cycle per request; never asserted in RESP or for err/be=0.
REQ-032 gnt_o, rsp_valid_o, ram_we_o never both bits / never outside the states above.

Reset
REQ-033 rst_n asserted: state = IDLE, prio = 0, captured regs = 0; gnt_o, rsp_valid_o, rsp_err_o, ram_we_o = 0; rsp_rdata_o = 0.
REQ-034 Reset during MERGE or RESP: in-flight request dropped, no RAM write, no response; first post-reset request arbitrated with prio = 0.

Verification
REQ-035 Port0 write addr 0x8, wdata 0xDEADBEEF, be 1111; then port1 read 0x8 -> gnt_o=01, rsp next cycle; then gnt_o=10, rsp_valid_o=10, rsp_rdata_o=0xDEADBEEF.
REQ-036 Word 2 = 0xDEADBEEF; port0 write be 0100, wdata 0x00AA0000 -> ram_we_o only in MERGE, word 2 = 0xDEAABEEF, rsp 2 cycles after gnt.
REQ-037 Both ports request continuously after reset -> grants alternate 01, 10, 01, 10.
REQ-038 Port1 read addr 0x24 (word 9, DEPTH 9) -> rsp_err_o = 1, rsp_rdata_o = 0, ram_we_o never 1.
REQ-039 Assert rst_n during MERGE of partial write to word 3 -> word 3 unchanged, no rsp_valid_o, outputs 0 next cycle.
REQ-040 Port0 write be 0000 -> rsp_valid_o = 01, rsp_err_o = 0, RAM contents unchanged.
